// File: rtl/uart_pkg.sv
// Shared UART constants and divisor helpers. The divisor helpers compute the fixed-point tick
// divisor (period minus one cycle) from the clock and baud rates.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_DIV  = 325;
  localparam int unsigned UART_DEFAULT_FRAC = 0;
  localparam int unsigned UART_OVERSAMPLE   = 16;

  // Fixed-point (D.F) divisor, rounded to nearest; the "+1 cycle" of the period is removed.
  function automatic longint unsigned calc_div_fixed(input longint unsigned clk_freq,
                                                     input longint unsigned baud,
                                                     input longint unsigned oversample,
                                                     input int unsigned     frac_bits);
    longint unsigned rate;
    rate = baud * oversample;
    return ((clk_freq << frac_bits) + (rate >> 1)) / rate - (64'd1 << frac_bits);
  endfunction

  function automatic int unsigned calc_div_int(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned oversample,
                                               input int unsigned     frac_bits);
    return 32'(calc_div_fixed(clk_freq, baud, oversample, frac_bits) >> frac_bits);
  endfunction

  function automatic int unsigned calc_div_frac(input longint unsigned clk_freq,
                                                input longint unsigned baud,
                                                input longint unsigned oversample,
                                                input int unsigned     frac_bits);
    return 32'(calc_div_fixed(clk_freq, baud, oversample, frac_bits) &
               ((64'd1 << frac_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional accumulator for the baud generator. The carry out of each tick's accumulation
// stretches the following period by one cycle.
module baud_frac_accum #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_advance,
  input  logic [DIV_WIDTH-1:0] i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  output logic [DIV_WIDTH:0]   o_term
);

  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic                 ext_q, ext_d;

  always_comb begin
    acc_d = acc_q;
    ext_d = ext_q;
    if (i_clear) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (i_advance) begin
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, i_div_frac};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
  end

  assign o_term = {1'b0, i_div_int} + {{DIV_WIDTH{1'b0}}, ext_q};

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate tick generator: oversample tick every D+1(+ext) enabled cycles and a bit
// tick every OVERSAMPLE-th oversample tick, with glitch-free divisor reload at period boundaries.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_BITS    = 4,
  parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV  = UART_DEFAULT_DIV,
  parameter int unsigned DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_sync_clear,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  output logic                 o_os_tick,
  output logic                 o_bit_tick,
  output logic                 o_load_pending
);

  localparam int unsigned          OcWidth = $clog2(OVERSAMPLE);
  localparam logic [OcWidth-1:0]   OcLast  = OcWidth'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0] DivRst  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [FRAC_BITS-1:0] FracRst = FRAC_BITS'(DEFAULT_FRAC);

  logic [DIV_WIDTH:0]   cnt_q, cnt_d;
  logic [OcWidth-1:0]   oc_q, oc_d;
  logic [DIV_WIDTH-1:0] div_int_q, div_int_d, sh_int_q, sh_int_d;
  logic [FRAC_BITS-1:0] div_frac_q, div_frac_d, sh_frac_q, sh_frac_d;
  logic                 pend_q, pend_d;
  logic                 os_tick_q, os_tick_d, bit_tick_q, bit_tick_d;
  logic [DIV_WIDTH:0]   term;
  logic                 boundary, apply;

  baud_frac_accum #(
    .DIV_WIDTH(DIV_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_accum (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (i_sync_clear),
    .i_advance (boundary),
    .i_div_int (div_int_q),
    .i_div_frac(div_frac_q),
    .o_term    (term)
  );

  always_comb begin
    boundary   = i_enable && !i_sync_clear && (cnt_q == term);
    // A frozen or restarted counter has no period in flight, so a new divisor is safe to apply.
    apply      = i_sync_clear || !i_enable || boundary;
    cnt_d      = cnt_q;
    oc_d       = oc_q;
    os_tick_d  = boundary;
    bit_tick_d = boundary && (oc_q == OcLast);
    if (i_sync_clear) begin
      cnt_d = '0;
      oc_d  = '0;
    end else if (i_enable) begin
      if (boundary) begin
        cnt_d = '0;
        oc_d  = (oc_q == OcLast) ? '0 : oc_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    pend_d     = pend_q;
    if (i_load) begin
      sh_int_d  = i_div_int;
      sh_frac_d = i_div_frac;
    end
    if (apply) begin
      pend_d = 1'b0;
      if (i_load) begin
        div_int_d  = i_div_int;
        div_frac_d = i_div_frac;
      end else if (pend_q) begin
        div_int_d  = sh_int_q;
        div_frac_d = sh_frac_q;
      end
    end else if (i_load) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= '0;
      oc_q       <= '0;
      div_int_q  <= DivRst;
      div_frac_q <= FracRst;
      sh_int_q   <= DivRst;
      sh_frac_q  <= FracRst;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      oc_q       <= oc_d;
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign o_os_tick      = os_tick_q;
  assign o_bit_tick     = bit_tick_q;
  assign o_load_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus randomized traffic, all checked against a
// period-length / running-fraction reference model.
module tb_baud_gen_frac;

  localparam int unsigned DW       = 16;
  localparam int unsigned FB       = 4;
  localparam int unsigned OS       = 4;
  localparam int unsigned DEF_DIV  = 5;
  localparam int unsigned DEF_FRAC = 3;
  localparam int          FRAC_ONE = 1 << FB;

  logic          i_clk, i_reset, i_enable, i_sync_clear, i_load;
  logic [DW-1:0] i_div_int;
  logic [FB-1:0] i_div_frac;
  logic          o_os_tick, o_bit_tick, o_load_pending;

  int n_checks, n_fail;

  // Reference model: elapsed enabled cycles in the period, its length from D/F, the running
  // fractional sum (ext = whether that sum crossed a whole cycle), and total ticks since clear.
  int m_div, m_frac, m_sh_div, m_sh_frac, m_done, m_ext, m_sum, m_ticks;
  bit m_pend, exp_os, exp_bit;

  baud_gen_frac #(
    .DIV_WIDTH   (DW),
    .FRAC_BITS   (FB),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DEF_DIV),
    .DEFAULT_FRAC(DEF_FRAC)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_sync_clear  (i_sync_clear),
    .i_load        (i_load),
    .i_div_int     (i_div_int),
    .i_div_frac    (i_div_frac),
    .o_os_tick     (o_os_tick),
    .o_bit_tick    (o_bit_tick),
    .o_load_pending(o_load_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    m_div = DEF_DIV; m_frac = DEF_FRAC; m_sh_div = DEF_DIV; m_sh_frac = DEF_FRAC;
    m_done = 0; m_ext = 0; m_sum = 0; m_ticks = 0; m_pend = 1'b0;
    exp_os = 1'b0; exp_bit = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit sc, input bit ld,
                                     input int d, input int f);
    bit bnd;
    bnd = 1'b0;
    exp_os = 1'b0;
    exp_bit = 1'b0;
    if (sc) begin
      m_done = 0; m_sum = 0; m_ext = 0; m_ticks = 0;
    end else if (en) begin
      m_done++;
      if (m_done == m_div + 1 + m_ext) begin
        bnd = 1'b1;
        exp_os = 1'b1;
        m_ticks++;
        exp_bit = (m_ticks % OS) == 0;
        m_done = 0;
        m_ext = (m_sum + m_frac) / FRAC_ONE - m_sum / FRAC_ONE;
        m_sum += m_frac;
      end
    end
    if (ld) begin
      m_sh_div = d; m_sh_frac = f;
    end
    if (sc || !en || bnd) begin
      if (ld) begin
        m_div = d; m_frac = f;
      end else if (m_pend) begin
        m_div = m_sh_div; m_frac = m_sh_frac;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
  endfunction

  task automatic drive_cycle(input bit en, input bit sc, input bit ld, input int d, input int f);
    i_enable = en; i_sync_clear = sc; i_load = ld;
    i_div_int = DW'(d); i_div_frac = FB'(f);
    @(posedge i_clk);
    model_step(en, sc, ld, d, f);
    #1;
  endtask

  task automatic test_reset();
    int first;
    i_reset = 1'b1; i_enable = 1'b1; i_sync_clear = 1'b0; i_load = 1'b0;
    i_div_int = '0; i_div_frac = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_os_tick, o_bit_tick, o_load_pending} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000", {o_os_tick, o_bit_tick, o_load_pending});
    end
    i_reset = 1'b0;
    model_reset();
    first = 0;
    for (int c = 1; c <= 60; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL reset_run cyc %0d: got %b want %b", c,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick && first == 0) first = c;
    end
    n_checks++;
    if (first != DEF_DIV + 1) begin
      n_fail++;
      $display("FAIL reset_first_tick: got edge %0d want %0d", first, DEF_DIV + 1);
    end
  endtask

  task automatic test_int_div();
    int n_os, n_bit;
    n_os = 0; n_bit = 0;
    drive_cycle(1, 1, 1, 3, 0);
    for (int c = 1; c <= 48; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL int_div cyc %0d: got %b want %b", c,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick) begin
        n_os++;
        n_checks++;
        if (c % 4 != 0) begin
          n_fail++;
          $display("FAIL int_div_os_phase: tick at edge %0d, want multiple of 4", c);
        end
      end
      if (o_bit_tick) begin
        n_bit++;
        n_checks++;
        if (c % 16 != 0 || !o_os_tick) begin
          n_fail++;
          $display("FAIL int_div_bit_phase: bit tick at edge %0d os=%b, want multiple of 16",
                   c, o_os_tick);
        end
      end
    end
    n_checks++;
    if (n_os != 12 || n_bit != 3) begin
      n_fail++;
      $display("FAIL int_div_counts: got os=%0d bit=%0d want os=12 bit=3", n_os, n_bit);
    end
  endtask

  task automatic test_frac();
    int t[$];
    drive_cycle(1, 1, 1, 3, 8);
    for (int c = 1; c <= 120 && t.size() < 21; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL frac cyc %0d: got %b want %b", c,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick) t.push_back(c);
    end
    n_checks++;
    if (t.size() < 21) begin
      n_fail++;
      $display("FAIL frac_timeout: got %0d ticks want 21", t.size());
    end else if (t[0] != 4 || t[1] != 8 || t[2] != 13 || t[3] != 17 || t[4] != 22 ||
                 t[20] - t[0] != 90) begin
      n_fail++;
      $display("FAIL frac_periods: got %0d,%0d,%0d,%0d,%0d span %0d want 4,8,13,17,22 span 90",
               t[0], t[1], t[2], t[3], t[4], t[20] - t[0]);
    end
  endtask

  task automatic test_load_mid();
    int t[$];
    int pend_cycles;
    bit found;
    found = 1'b0;
    drive_cycle(1, 1, 1, 3, 0);
    for (int c = 0; c < 10 && !found; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      if (o_os_tick) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL load_mid_timeout: got no tick want one within 10 edges");
    end
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 1, 7, 0);
    pend_cycles = o_load_pending ? 1 : 0;
    for (int e = 3; e <= 20; e++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL load_mid edge %0d: got %b want %b", e,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_load_pending) pend_cycles++;
      if (o_os_tick) t.push_back(e);
    end
    n_checks++;
    if (t.size() < 2 || t[0] != 4 || t[1] != 12 || pend_cycles != 2) begin
      n_fail++;
      $display("FAIL load_mid_timing: got ticks=%p pending=%0d want ticks 4,12 pending 2",
               t, pend_cycles);
    end
  endtask

  task automatic test_sync_clear();
    int n, gap, osn, bit_at;
    n = 0; gap = 0; osn = 0; bit_at = 0;
    drive_cycle(1, 1, 1, 3, 0);
    for (int c = 0; c < 40 && n < 3; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      if (o_os_tick) n++;
    end
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    n_checks++;
    if ({o_os_tick, o_bit_tick} !== 2'b00 || n != 3) begin
      n_fail++;
      $display("FAIL sync_clear_edge: got ticks %b prior os %0d want 00 and 3",
               {o_os_tick, o_bit_tick}, n);
    end
    for (int e = 1; e <= 40 && bit_at == 0; e++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL sync_clear edge %0d: got %b want %b", e,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick) begin
        osn++;
        if (gap == 0) gap = e;
      end
      if (o_bit_tick) bit_at = osn;
    end
    n_checks++;
    if (gap != 4 || bit_at != 4) begin
      n_fail++;
      $display("FAIL sync_clear_timing: got gap %0d bit at os %0d want 4 and 4", gap, bit_at);
    end
  endtask

  task automatic test_enable_freeze();
    int gap;
    int t[$];
    gap = 0;
    drive_cycle(1, 1, 1, 3, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(0, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== 3'b000) begin
        n_fail++;
        $display("FAIL freeze_ticks cyc %0d: got %b want 000", c,
                 {o_os_tick, o_bit_tick, o_load_pending});
      end
    end
    for (int e = 1; e <= 10 && gap == 0; e++) begin
      drive_cycle(1, 0, 0, 0, 0);
      if (o_os_tick) gap = e;
    end
    n_checks++;
    if (gap != 2) begin
      n_fail++;
      $display("FAIL freeze_resume: got tick after %0d edges want 2", gap);
    end
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 6, 0);
    n_checks++;
    if (o_load_pending !== 1'b0 || o_os_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_load: got pending=%b os=%b want 0 0", o_load_pending, o_os_tick);
    end
    for (int e = 1; e <= 20; e++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL disabled_load edge %0d: got %b want %b", e,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick) t.push_back(e);
    end
    n_checks++;
    if (t.size() < 2 || t[0] != 6 || t[1] != 13) begin
      n_fail++;
      $display("FAIL disabled_load_timing: got ticks=%p want 6,13", t);
    end
  endtask

  task automatic test_div_zero();
    int n_os, n_bit;
    int t[$];
    n_os = 0; n_bit = 0;
    drive_cycle(1, 1, 1, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      if (o_os_tick) n_os++;
      if (o_bit_tick) n_bit++;
    end
    n_checks++;
    if (n_os != 8 || n_bit != 2) begin
      n_fail++;
      $display("FAIL div_zero_counts: got os=%0d bit=%0d want 8 and 2", n_os, n_bit);
    end
    drive_cycle(1, 1, 1, 0, 8);
    for (int c = 1; c <= 8; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL div_zero_frac cyc %0d: got %b want %b", c,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick) t.push_back(c);
    end
    n_checks++;
    if (t.size() < 5 || t[0] != 1 || t[1] != 2 || t[2] != 4 || t[3] != 5 || t[4] != 7) begin
      n_fail++;
      $display("FAIL div_zero_frac_timing: got ticks=%p want 1,2,4,5,7", t);
    end
  endtask

  task automatic test_random();
    bit en, sc, ld;
    drive_cycle(1, 1, 1, 3, 0);
    for (int c = 0; c < 3000; c++) begin
      en = m_pend || ($urandom_range(0, 19) != 0);
      sc = ($urandom_range(0, 49) == 0);
      ld = en && ($urandom_range(0, 9) == 0);
      drive_cycle(en, sc, ld, int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL random cyc %0d en=%b sc=%b ld=%b: got %b want %b", c, en, sc, ld,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = 0;
    drive_cycle(1, 1, 1, 3, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 1, 9, 2);
    n_checks++;
    if (o_load_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got pending=%b want 1", o_load_pending);
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_os_tick, o_bit_tick, o_load_pending} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want 000", {o_os_tick, o_bit_tick, o_load_pending});
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 60; c++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if ({o_os_tick, o_bit_tick, o_load_pending} !== {exp_os, exp_bit, m_pend}) begin
        n_fail++;
        $display("FAIL reset_mid_run cyc %0d: got %b want %b", c,
                 {o_os_tick, o_bit_tick, o_load_pending}, {exp_os, exp_bit, m_pend});
      end
      if (o_os_tick && first == 0) first = c;
    end
    n_checks++;
    if (first != DEF_DIV + 1) begin
      n_fail++;
      $display("FAIL reset_mid_default: got first tick %0d want %0d", first, DEF_DIV + 1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_reset();
    test_reset();
    test_int_div();
    test_frac();
    test_load_mid();
    test_sync_clear();
    test_enable_freeze();
    test_div_zero();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
